// File: rtl/face_detect_mul_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined unsigned x signed multiplier among N_REQ requesters.
// Optional statistics counters are enabled by defining FACE_DETECT_MUL_ARB_STATS_EN.
module face_detect_mul_rr_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned A_W         = 16,
  parameter int unsigned B_W         = 10,
  parameter int unsigned P_W         = 26,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [P_W-1:0]       rsp_data,
  output logic                 mul_ce,
  output logic [A_W-1:0]       mul_din0,
  output logic [B_W-1:0]       mul_din1,
  input  logic [P_W-1:0]       mul_dout
`ifdef FACE_DETECT_MUL_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0]  stat_grants,
  output logic [31:0]          stat_conflict
`endif
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  logic [IdxW-1:0]        ptr_q;
  logic [IdxW-1:0]        grant_idx;
  logic [IdxW-1:0]        cand;
  logic                   grant_any;
  logic                   handshake;
  logic [MUL_LATENCY-1:0] tv_q;
  logic [IdxW-1:0]        tag_q [MUL_LATENCY];

  // Scan from farthest to nearest so the nearest valid requester after ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = int'(N_REQ); off >= 1; off--) begin
      cand = IdxW'((int'(ptr_q) + off) % int'(N_REQ));
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign handshake = grant_any & ~stall & ~reset;

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    if (handshake) begin
      req_ready[grant_idx] = 1'b1;
      mul_din0             = req_a[grant_idx*A_W +: A_W];
      mul_din1             = req_b[grant_idx*B_W +: B_W];
    end
  end

  assign mul_ce = ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= IdxW'(N_REQ - 1);
      tv_q  <= '0;
      for (int i = 0; i < int'(MUL_LATENCY); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      if (handshake) begin
        ptr_q <= grant_idx;
      end
      // Tags move in lockstep with the multiplier's ce-qualified stages.
      if (!stall) begin
        tv_q[0]  <= handshake;
        tag_q[0] <= grant_idx;
        for (int i = 1; i < int'(MUL_LATENCY); i++) begin
          tv_q[i]  <= tv_q[i-1];
          tag_q[i] <= tag_q[i-1];
        end
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      rsp_valid[k] = tv_q[MUL_LATENCY-1] & (tag_q[MUL_LATENCY-1] == IdxW'(k)) & ~stall;
    end
  end

  assign rsp_data = mul_dout;

`ifdef FACE_DETECT_MUL_ARB_STATS_EN
  logic [31:0] grant_cnt_q [N_REQ];
  logic [31:0] conflict_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_q <= '0;
      for (int k = 0; k < int'(N_REQ); k++) begin
        grant_cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(N_REQ); k++) begin
        if (handshake && grant_idx == IdxW'(k) && grant_cnt_q[k] != '1) begin
          grant_cnt_q[k] <= grant_cnt_q[k] + 32'd1;
        end
      end
      if (!stall && $countones(req_valid) >= 2 && conflict_q != '1) begin
        conflict_q <= conflict_q + 32'd1;
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      stat_grants[k*32 +: 32] = grant_cnt_q[k];
    end
  end

  assign stat_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_face_detect_mul_rr_arbiter.sv
// Scoreboard bench: stimulus process predicts grants/products, monitor process checks responses.
module tb_face_detect_mul_rr_arbiter;
  localparam int N = 4;
  localparam int AW = 16;
  localparam int BW = 10;
  localparam int PW = 26;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            stall = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [PW-1:0]   rsp_data;
  logic            mul_ce;
  logic [AW-1:0]   mul_din0;
  logic [BW-1:0]   mul_din1;
  logic [PW-1:0]   mul_dout;
`ifdef FACE_DETECT_MUL_ARB_STATS_EN
  logic [N*32-1:0] stat_grants;
  logic [31:0]     stat_conflict;
`endif

  face_detect_mul_rr_arbiter #(
    .N_REQ(N), .A_W(AW), .B_W(BW), .P_W(PW), .MUL_LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mul_ce    (mul_ce),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout)
`ifdef FACE_DETECT_MUL_ARB_STATS_EN
    ,
    .stat_grants   (stat_grants),
    .stat_conflict (stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  // Attached multiplier: LAT ce-qualified stages.
  logic signed [PW-1:0] mpipe [LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= $signed({1'b0, mul_din0}) * $signed(mul_din1);
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_dout = mpipe[LAT-1];

  typedef struct {int tag; longint prod; int due;} exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int ns_stim = 0;
  int ns_mon = 0;
  int rr_last = N - 1;
  int dut_grant;
  int rsp_pulses = 0;
  logic [PW-1:0] last_rsp_data;
  bit             pend_v [N];
  logic [AW-1:0]  pend_a [N];
  logic [BW-1:0]  pend_b [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pend_v[i];
      req_a[i*AW +: AW]     = pend_a[i];
      req_b[i*BW +: BW]     = pend_b[i];
    end
  endtask

  task automatic raise(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    pend_v[i] = 1'b1;
    pend_a[i] = a;
    pend_b[i] = b;
  endtask

  // One cycle: inputs are already applied; predict and check at the falling edge.
  task automatic step();
    int exp_g;
    exp_g = -1;
    @(negedge clk);
    if (!reset && !stall) begin
      for (int off = 1; off <= N; off++) begin
        int j;
        j = (rr_last + off) % N;
        if (pend_v[j] && exp_g < 0) exp_g = j;
      end
    end
    dut_grant = -1;
    for (int i = 0; i < N; i++) if (req_ready[i]) dut_grant = i;
    chk("req_ready", 64'(req_ready), (exp_g >= 0) ? 64'(1) << exp_g : 64'(0));
    chk("mul_ce", 64'(mul_ce), 64'(!stall));
    chk("mul_din0", 64'(mul_din0), (exp_g >= 0) ? 64'(pend_a[exp_g]) : 64'(0));
    chk("mul_din1", 64'(mul_din1), (exp_g >= 0) ? 64'(pend_b[exp_g]) : 64'(0));
    if (exp_g >= 0) begin
      q.push_back('{exp_g, longint'(pend_a[exp_g]) * longint'($signed(pend_b[exp_g])),
                    ns_stim + LAT});
      rr_last = exp_g;
      pend_v[exp_g] = 1'b0;
    end
    if (reset) begin
      q.delete();
      ns_stim = 0;
      rr_last = N - 1;
    end else if (!stall) begin
      ns_stim++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: a result is due on the LAT-th non-stall cycle after its issue cycle.
  always @(negedge clk) begin
    if (reset) begin
      chk("rsp_valid_in_reset", 64'(rsp_valid), 64'(0));
      ns_mon = 0;
    end else if (stall) begin
      chk("rsp_valid_in_stall", 64'(rsp_valid), 64'(0));
    end else begin
      if (rsp_valid != '0) begin
        rsp_pulses++;
        last_rsp_data = rsp_data;
      end
      if (q.size() > 0 && q[0].due == ns_mon) begin
        chk("rsp_valid", 64'(rsp_valid), 64'(1) << q[0].tag);
        chk("rsp_data", 64'($signed(rsp_data)), 64'(q[0].prod));
        void'(q.pop_front());
      end else begin
        chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
      end
      ns_mon++;
    end
  end

  task automatic clear_pend();
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0;
      pend_a[i] = '0;
      pend_b[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    clear_pend();
    drive();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      step();
    end
  endtask

  initial begin
    int p0;
    clear_pend();
    drive();
    do_reset();

    // Reset mid-flight: the in-flight product must never be reported.
    raise(1, 16'h1234, 10'h155);
    drive();
    step();
    chk("midflight_grant", 64'(dut_grant), 64'(1));
    reset = 1'b1;
    raise(2, 16'h0042, 10'h003);
    drive();
    step();
    chk("reset_din0", 64'(mul_din0), 64'(0));
    clear_pend();
    drive();
    step();
    reset = 1'b0;
    idle(LAT + 2);

    // Single issue, extreme operands.
    raise(0, 16'hFFFF, 10'h200);
    drive();
    step();
    chk("single_grant", 64'(dut_grant), 64'(0));
    p0 = rsp_pulses;
    idle(LAT + 1);
    chk("single_pulses", 64'(rsp_pulses - p0), 64'(1));
    chk("single_data", 64'($signed(last_rsp_data)), 64'(-33553920));

    // Fairness: all requesters continuously valid.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend_v[i]) raise(i, 16'($urandom), 10'($urandom));
      drive();
      step();
      chk("fair_grant", 64'(dut_grant), 64'(c % N));
    end
    clear_pend();
    drive();
    step();
`ifdef FACE_DETECT_MUL_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stat_grants", 64'(stat_grants[i*32 +: 32]), 64'(2));
    chk("stat_conflict", 64'(stat_conflict), 64'(8));
`endif
    idle(LAT + 1);
    do_reset();
`ifdef FACE_DETECT_MUL_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stat_grants_rst", 64'(stat_grants[i*32 +: 32]), 64'(0));
    chk("stat_conflict_rst", 64'(stat_conflict), 64'(0));
`endif

    // Stall after a grant: one pulse, delayed by two cycles.
    raise(0, 16'd300, 10'h3F0);
    drive();
    step();
    p0 = rsp_pulses;
    stall = 1'b1;
    raise(3, 16'd7, 10'd9);
    drive();
    step();
    step();
    chk("stall_no_grant", 64'(dut_grant), 64'(-1));
    stall = 1'b0;
    clear_pend();
    idle(LAT + 2);
    chk("stall_pulses", 64'(rsp_pulses - p0), 64'(1));

    // Sparse request and wrap from pointer 3.
    do_reset();
    raise(2, 16'd11, 10'd5);
    drive();
    step();
    chk("sparse_grant2", 64'(dut_grant), 64'(2));
    raise(0, 16'd3, 10'h3FF);
    raise(2, 16'd4, 10'd100);
    drive();
    step();
    chk("wrap_grant0", 64'(dut_grant), 64'(0));
    drive();
    step();
    chk("wrap_grant2", 64'(dut_grant), 64'(2));
    idle(LAT + 1);

    // Randomized traffic with random stalls.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend_v[i] && $urandom_range(0, 2) == 0) raise(i, 16'($urandom), 10'($urandom));
      stall = ($urandom_range(0, 5) == 0);
      drive();
      step();
    end
    stall = 1'b0;
    clear_pend();
    idle(LAT + 2);
    chk("drain_empty", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
